// File: rtl/data_memory_access.sv
// MEM-stage load/store sequencer: alignment check, byte-lane steering and a
// ready handshake with timeout toward a word-addressed data memory.
module data_memory_access #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        start_in,
   input  logic        write_in,
   input  logic [31:0] addr_in,
   input  logic [1:0]  size_in,
   input  logic [31:0] wdata_in,
   output logic [31:0] mem_addr_out,
   output logic        mem_read_out,
   output logic        mem_write_out,
   output logic [3:0]  mem_byte_en_out,
   output logic [31:0] mem_wdata_out,
   input  logic [31:0] mem_rdata_in,
   input  logic        mem_ready_in,
   output logic        busy_out,
   output logic        done_out,
   output logic [31:0] rdata_out,
   output logic [1:0]  size_out,
   output logic        misaligned_out,
   output logic        timeout_out
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          write_q;
   logic [31:0]   addr_q;
   logic [1:0]    size_q;
   logic [31:0]   wdata_q;
   logic [3:0]    be_q;
   logic [31:0]   rdata_q;
   logic [1:0]    size_out_q;
   logic          to_q;

   logic          aligned;
   logic [3:0]    be_calc;
   logic [31:0]   wdata_calc;
   logic [31:0]   rd_shift;
   logic [31:0]   rd_masked;

   // Request decode on the incoming (not yet captured) request
   always_comb begin
      aligned    = 1'b1;
      be_calc    = 4'b1111;
      wdata_calc = wdata_in;
      case (size_in)
         2'b00: begin
            be_calc    = 4'b0001 << addr_in[1:0];
            wdata_calc = {4{wdata_in[7:0]}};
         end
         2'b01: begin
            aligned    = ~addr_in[0];
            be_calc    = addr_in[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{wdata_in[15:0]}};
         end
         default: aligned = (addr_in[1:0] == 2'b00);
      endcase
   end

   always_comb begin
      rd_shift  = mem_rdata_in >> {addr_q[1:0], 3'b000};
      rd_masked = rd_shift;
      case (size_q)
         2'b00:   rd_masked = {24'd0, rd_shift[7:0]};
         2'b01:   rd_masked = {16'd0, rd_shift[15:0]};
         default: rd_masked = rd_shift;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start_in) begin
               cnt_d   = '0;
               state_d = aligned ? ACCESS : FAULT;
            end
         end
         ACCESS: begin
            if (mem_ready_in)      state_d = DONE;
            else if (cnt_q == LAST) state_d = FAULT;
            else                    cnt_d = cnt_q + CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // Captured request, load result and fault cause
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         write_q    <= 1'b0;
         addr_q     <= '0;
         size_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         rdata_q    <= '0;
         size_out_q <= '0;
         to_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_in) begin
                  write_q <= write_in;
                  addr_q  <= addr_in;
                  size_q  <= size_in;
                  wdata_q <= wdata_calc;
                  be_q    <= be_calc;
                  if (!aligned) begin
                     rdata_q    <= '0;
                     size_out_q <= size_in;
                     to_q       <= 1'b0;
                  end
               end
            end
            ACCESS: begin
               if (mem_ready_in) begin
                  rdata_q    <= write_q ? 32'd0 : rd_masked;
                  size_out_q <= size_q;
               end else if (cnt_q == LAST) begin
                  rdata_q    <= '0;
                  size_out_q <= size_q;
                  to_q       <= 1'b1;
               end
            end
            FAULT:   to_q <= 1'b0;
            default: ;
         endcase
      end
   end

   always_comb begin
      busy_out       = (state_q != IDLE);
      done_out       = (state_q == DONE) || (state_q == FAULT);
      mem_read_out   = (state_q == ACCESS) && !write_q;
      mem_write_out  = (state_q == ACCESS) && write_q;
      misaligned_out = (state_q == FAULT) && !to_q;
      timeout_out    = (state_q == FAULT) && to_q;
   end

   assign mem_addr_out    = {addr_q[31:2], 2'b00};
   assign mem_byte_en_out = be_q;
   assign mem_wdata_out   = wdata_q;
   assign rdata_out       = rdata_q;
   assign size_out        = size_out_q;

endmodule

// File: tb/tb_data_memory_access.sv
// Directed bench for data_memory_access: loads, stores, faults, reset abort
// and back-to-back starts, checked with immediate assertions.
module tb_data_memory_access;

   logic        clk_in = 1'b0;
   logic        reset_in, start_in, write_in, mem_ready_in;
   logic [31:0] addr_in, wdata_in, mem_rdata_in;
   logic [1:0]  size_in;
   logic [31:0] mem_addr_out, mem_wdata_out, rdata_out;
   logic        mem_read_out, mem_write_out, busy_out, done_out;
   logic        misaligned_out, timeout_out;
   logic [3:0]  mem_byte_en_out;
   logic [1:0]  size_out;

   int total = 0;
   int bad   = 0;

   data_memory_access #(.TIMEOUT(16)) dut (
      .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in),
      .write_in(write_in), .addr_in(addr_in), .size_in(size_in),
      .wdata_in(wdata_in), .mem_addr_out(mem_addr_out),
      .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
      .mem_byte_en_out(mem_byte_en_out), .mem_wdata_out(mem_wdata_out),
      .mem_rdata_in(mem_rdata_in), .mem_ready_in(mem_ready_in),
      .busy_out(busy_out), .done_out(done_out), .rdata_out(rdata_out),
      .size_out(size_out), .misaligned_out(misaligned_out),
      .timeout_out(timeout_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_req(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] wd);
      start_in = 1'b1; write_in = wr; addr_in = a; size_in = sz; wdata_in = wd;
      tick();
      start_in = 1'b0;
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_busy"}, busy_out, 0);
      chk({tag, "_done"}, done_out, 0);
      chk({tag, "_rd"}, mem_read_out, 0);
      chk({tag, "_wr"}, mem_write_out, 0);
      chk({tag, "_addr"}, mem_addr_out, 0);
      chk({tag, "_be"}, mem_byte_en_out, 0);
      chk({tag, "_wdata"}, mem_wdata_out, 0);
      chk({tag, "_rdata"}, rdata_out, 0);
      chk({tag, "_size"}, size_out, 0);
      chk({tag, "_mis"}, misaligned_out, 0);
      chk({tag, "_to"}, timeout_out, 0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_in = 1'b1; start_in = 1'b0; write_in = 1'b0; addr_in = '0;
      size_in = '0; wdata_in = '0; mem_rdata_in = '0; mem_ready_in = 1'b0;
      tick(); tick();
      reset_in = 1'b0;
      check_idle_zero("reset");
      $display("txn reset");

      // Load byte, offset 3, zero wait
      start_req(1'b0, 32'h0000_1003, 2'b00, 32'h0);
      chk("lb_rd", mem_read_out, 1);
      chk("lb_wr", mem_write_out, 0);
      chk("lb_addr", mem_addr_out, 32'h0000_1000);
      chk("lb_be", mem_byte_en_out, 4'b1000);
      chk("lb_busy", busy_out, 1);
      chk("lb_done_early", done_out, 0);
      mem_ready_in = 1'b1; mem_rdata_in = 32'hAABB_CCDD;
      tick();
      mem_ready_in = 1'b0;
      chk("lb_done", done_out, 1);
      chk("lb_rdata", rdata_out, 32'h0000_00AA);
      chk("lb_size", size_out, 2'b00);
      chk("lb_rd_off", mem_read_out, 0);
      chk("lb_busy_done", busy_out, 1);
      tick();
      chk("lb_busy_end", busy_out, 0);
      chk("lb_done_end", done_out, 0);
      chk("lb_rdata_hold", rdata_out, 32'h0000_00AA);
      $display("txn load byte 0x1003 rdata=%h", rdata_out);

      // Store half at offset 2, ready in the third access cycle
      start_req(1'b1, 32'h0000_2002, 2'b01, 32'h1234_5678);
      for (int i = 0; i < 3; i++) begin
         chk("sh_wr", mem_write_out, 1);
         chk("sh_rd", mem_read_out, 0);
         chk("sh_be", mem_byte_en_out, 4'b1100);
         chk("sh_wdata", mem_wdata_out, 32'h5678_5678);
         chk("sh_addr", mem_addr_out, 32'h0000_2000);
         chk("sh_done_early", done_out, 0);
         if (i == 2) mem_ready_in = 1'b1;
         tick();
      end
      mem_ready_in = 1'b0;
      chk("sh_done", done_out, 1);
      chk("sh_wr_off", mem_write_out, 0);
      chk("sh_rdata", rdata_out, 0);
      chk("sh_size", size_out, 2'b01);
      tick();
      chk("sh_busy_end", busy_out, 0);
      $display("txn store half 0x2002 wdata=%h", mem_wdata_out);

      // Load half at offset 2, then word via size code 10
      start_req(1'b0, 32'h0000_3002, 2'b01, 32'h0);
      chk("lh_be", mem_byte_en_out, 4'b1100);
      mem_ready_in = 1'b1; mem_rdata_in = 32'hAABB_CCDD;
      tick();
      mem_ready_in = 1'b0;
      chk("lh_rdata", rdata_out, 32'h0000_AABB);
      tick();
      $display("txn load half 0x3002 rdata=%h", rdata_out);
      start_req(1'b0, 32'h0000_3008, 2'b10, 32'h0);
      chk("lw10_be", mem_byte_en_out, 4'b1111);
      mem_ready_in = 1'b1; mem_rdata_in = 32'h1122_3344;
      tick();
      mem_ready_in = 1'b0;
      chk("lw10_rdata", rdata_out, 32'h1122_3344);
      chk("lw10_size", size_out, 2'b10);
      tick();
      $display("txn load word(10) 0x3008 rdata=%h", rdata_out);

      // Misaligned word then half
      start_req(1'b0, 32'h0000_0006, 2'b11, 32'h0);
      chk("mw_done", done_out, 1);
      chk("mw_mis", misaligned_out, 1);
      chk("mw_to", timeout_out, 0);
      chk("mw_rd", mem_read_out, 0);
      chk("mw_wr", mem_write_out, 0);
      chk("mw_rdata", rdata_out, 0);
      chk("mw_busy", busy_out, 1);
      tick();
      chk("mw_mis_clr", misaligned_out, 0);
      chk("mw_done_clr", done_out, 0);
      chk("mw_busy_end", busy_out, 0);
      $display("txn misaligned word 0x0006");
      start_req(1'b0, 32'h0000_0001, 2'b01, 32'h0);
      chk("mh_done", done_out, 1);
      chk("mh_mis", misaligned_out, 1);
      chk("mh_rd", mem_read_out, 0);
      chk("mh_size", size_out, 2'b01);
      tick();
      chk("mh_mis_clr", misaligned_out, 0);
      $display("txn misaligned half 0x0001");

      // Timeout with ready held low: fault 17 cycles after start
      mem_rdata_in = 32'hFFFF_FFFF;
      start_req(1'b0, 32'h0000_0010, 2'b00, 32'h0);
      for (int i = 0; i < 16; i++) begin
         chk("to_rd", mem_read_out, 1);
         chk("to_done_early", done_out, 0);
         tick();
      end
      chk("to_done", done_out, 1);
      chk("to_flag", timeout_out, 1);
      chk("to_mis", misaligned_out, 0);
      chk("to_rd_off", mem_read_out, 0);
      chk("to_rdata", rdata_out, 0);
      tick();
      chk("to_flag_clr", timeout_out, 0);
      chk("to_busy_end", busy_out, 0);
      $display("txn timeout load 0x0010");

      // Ready on the 16th access cycle wins over the timeout
      start_req(1'b0, 32'h0000_0011, 2'b00, 32'h0);
      for (int i = 0; i < 16; i++) begin
         chk("late_rd", mem_read_out, 1);
         if (i == 15) begin
            mem_ready_in = 1'b1; mem_rdata_in = 32'h1234_5678;
         end
         tick();
      end
      mem_ready_in = 1'b0;
      chk("late_done", done_out, 1);
      chk("late_to", timeout_out, 0);
      chk("late_rdata", rdata_out, 32'h0000_0056);
      tick();
      $display("txn late ready 0x0011 rdata=%h", rdata_out);

      // Reset on the second access cycle
      start_req(1'b0, 32'h0000_0020, 2'b11, 32'h0);
      tick();
      chk("ra_rd", mem_read_out, 1);
      reset_in = 1'b1;
      tick();
      reset_in = 1'b0;
      check_idle_zero("ra");
      tick();
      chk("ra_no_done", done_out, 0);
      start_req(1'b0, 32'h0000_0020, 2'b11, 32'h0);
      mem_ready_in = 1'b1; mem_rdata_in = 32'hCAFE_F00D;
      tick();
      mem_ready_in = 1'b0;
      chk("ra_new_done", done_out, 1);
      chk("ra_new_rdata", rdata_out, 32'hCAFE_F00D);
      tick();
      $display("txn reset abort then load 0x0020 rdata=%h", rdata_out);

      // Start held high with zero-wait memory: one completion per 3 cycles
      start_in = 1'b1; write_in = 1'b0; addr_in = 32'h0; size_in = 2'b00;
      mem_ready_in = 1'b1; mem_rdata_in = 32'h89AB_CDEF;
      for (int c = 0; c < 12; c++) begin
         tick();
         chk("b2b_done", done_out, (c % 3 == 1) ? 1 : 0);
         chk("b2b_busy", busy_out, (c % 3 == 2) ? 0 : 1);
         if (c % 3 == 1) chk("b2b_rdata", rdata_out, 32'h0000_00EF);
      end
      start_in = 1'b0; mem_ready_in = 1'b0;
      tick(); tick();
      chk("b2b_idle", busy_out, 0);
      $display("txn back-to-back starts");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
